// File: rtl/fifo_arbiter_pkg.sv
// Shared constants and read-FSM state encoding for the sample FIFO arbiter.
package fifo_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam logic [7:0] MUTE_WORD_DEF = 8'h80;

  // RD names the read-issue phase, which happens in the WAIT cycle that consumes a tick
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    WAIT  = 2'd1,
    RD    = 2'd2,
    CAP   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_arbiter_if.sv
// Bundle of requester, FIFO and playback-side signals; master = arbiter, slave = surroundings.
interface fifo_arbiter_if
  import fifo_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_full;
  logic              fifo_threshold;
  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              sample_tick;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  underrun_cnt;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_full, fifo_threshold, fifo_empty, fifo_dout, sample_tick,
    output req0_ready, req1_ready, fifo_wr, fifo_din, fifo_rd,
    output out_data, out_valid, underrun_cnt
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_full, fifo_threshold, fifo_empty, fifo_dout, sample_tick,
    input  req0_ready, req1_ready, fifo_wr, fifo_din, fifo_rd,
    input  out_data, out_valid, underrun_cnt
  );

endinterface

// File: rtl/fifo_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_full,
  input  logic       i_rr_ptr,
  output logic [1:0] o_grant,
  output logic       o_rr_ptr_next
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign o_grant[gi] = !i_full && i_valid[gi] &&
                         (!i_valid[1-gi] || (i_rr_ptr == 1'(gi)));
  end

  assign o_rr_ptr_next = o_grant[0] ? 1'b1 :
                         o_grant[1] ? 1'b0 : i_rr_ptr;

endmodule

// File: rtl/fifo_arbiter.sv
// Shares the sample FIFO between two producers and drains it once per sample_tick.
// FIFO_ARB_UNDERRUN_HOLD_EN: repeat the last drained sample on underrun instead of MUTE_WORD.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              CNT_W     = CNT_W_DEF,
  parameter logic [DATA_W-1:0] MUTE_WORD = DATA_W'(MUTE_WORD_DEF)
) (
  input logic            clk,
  input logic            rst_n,
  fifo_arbiter_if.master bus
);

  logic [1:0] w_valid;
  logic [1:0] w_grant;
  logic       w_rr_ptr_next;
  logic       r_rr_ptr;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid       (w_valid),
    .i_full        (bus.fifo_full),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant       (w_grant),
    .o_rr_ptr_next (w_rr_ptr_next)
  );

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.fifo_wr    = |w_grant;
  assign bus.fifo_din   = w_grant[1] ? bus.req1_data :
                          w_grant[0] ? bus.req0_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  rd_state_t         r_state;
  rd_state_t         w_state_next;
  logic              r_tick_pend;
  logic              w_tick_clr;
  logic              w_rd;
  logic              w_underrun;
  logic              r_uflow_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_underrun_cnt;

  always_comb begin
    w_state_next = r_state;
    w_rd         = 1'b0;
    w_underrun   = 1'b0;
    w_tick_clr   = 1'b0;
    case (r_state)
      PRIME: begin
        if (bus.fifo_threshold) w_state_next = WAIT;
      end
      WAIT: begin
        if (r_tick_pend) begin
          w_tick_clr = 1'b1;
          if (!bus.fifo_empty) begin
            w_rd         = 1'b1;
            w_state_next = CAP;
          end else begin
            w_underrun   = 1'b1;
            w_state_next = PRIME;
          end
        end
      end
      CAP:     w_state_next = WAIT;
      default: w_state_next = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ticks seen while priming are dropped; ticks landing on a pending one are absorbed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_pend <= 1'b0;
    end else if (r_state == PRIME || w_tick_clr) begin
      r_tick_pend <= 1'b0;
    end else if (bus.sample_tick) begin
      r_tick_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data     <= MUTE_WORD;
      r_uflow_valid  <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_uflow_valid <= w_underrun;
      if (r_state == CAP) begin
        r_out_data <= bus.fifo_dout;
      end
      if (w_underrun) begin
`ifdef FIFO_ARB_UNDERRUN_HOLD_EN
        r_out_data <= r_out_data;
`else
        r_out_data <= MUTE_WORD;
`endif
        if (r_underrun_cnt != '1) begin
          r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
      end
    end
  end

  // The captured word is shown straight from the FIFO during CAP, then held in r_out_data
  assign bus.fifo_rd      = w_rd;
  assign bus.out_valid    = (r_state == CAP) || r_uflow_valid;
  assign bus.out_data     = (r_state == CAP) ? bus.fifo_dout : r_out_data;
  assign bus.underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: arbitration, drain timing, underrun, saturation, reset in CAP.
module tb_fifo_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem [0:7];
  int         rd_ptr   = 0;
  int         rd_count = 0;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [7:0] exp_word [0:1];
  logic [7:0] exp_ur;
  int         exp_g;

  fifo_arbiter_if #(.DATA_W(8), .CNT_W(8)) bus ();

  fifo_arbiter #(.DATA_W(8), .CNT_W(8), .MUTE_WORD(8'h80)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Registered-read FIFO model: data appears the cycle after fifo_rd
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      bus.fifo_dout <= mem[rd_ptr[2:0]];
      rd_ptr        <= rd_ptr + 1;
      rd_count      <= rd_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.req0_valid     = 1'b0;
    bus.req0_data      = 8'h00;
    bus.req1_valid     = 1'b0;
    bus.req1_data      = 8'h00;
    bus.fifo_full      = 1'b0;
    bus.fifo_threshold = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.sample_tick    = 1'b0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    exp_word[0] = 8'h11;
    exp_word[1] = 8'h22;
`ifdef FIFO_ARB_UNDERRUN_HOLD_EN
    exp_ur = 8'h22;
`else
    exp_ur = 8'h80;
`endif

    step();
    step();
    check_val("rst_out_data", bus.out_data, 8'h80);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_fifo_rd", bus.fifo_rd, 0);
    check_val("rst_fifo_wr", bus.fifo_wr, 0);
    check_val("rst_underrun_cnt", bus.underrun_cnt, 0);
    rst_n = 1'b1;
    step();

    // Both requesters valid: grants 0,1,0,1,0
    d0 = 8'hA0;
    d1 = 8'hB0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_data = d0;
      bus.req1_data = d1;
      #1;
      exp_g = i % 2;
      check_val($sformatf("rr%0d_ready0", i), bus.req0_ready, exp_g == 0);
      check_val($sformatf("rr%0d_ready1", i), bus.req1_ready, exp_g == 1);
      check_val($sformatf("rr%0d_wr", i), bus.fifo_wr, 1);
      check_val($sformatf("rr%0d_din", i), bus.fifo_din, (exp_g == 1) ? d1 : d0);
      if (exp_g == 0) d0 = d0 + 8'h01;
      else            d1 = d1 + 8'h01;
      step();
    end

    // Full blocks both; rr_ptr (now 1) must survive three blocked cycles
    bus.req0_data = d0;
    bus.req1_data = d1;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("full%0d_ready0", i), bus.req0_ready, 0);
      check_val($sformatf("full%0d_ready1", i), bus.req1_ready, 0);
      check_val($sformatf("full%0d_wr", i), bus.fifo_wr, 0);
      step();
    end
    bus.fifo_full = 1'b0;
    #1;
    check_val("unfull_ready1", bus.req1_ready, 1);
    check_val("unfull_ready0", bus.req0_ready, 0);
    check_val("unfull_din", bus.fifo_din, d1);
    step();
    d1 = d1 + 8'h01;
    bus.req1_data  = d1;
    bus.req0_valid = 1'b0;
    #1;
    check_val("single1_ready1", bus.req1_ready, 1);
    check_val("single1_din", bus.fifo_din, d1);
    step();
    bus.req1_valid = 1'b0;
    #1;
    check_val("idle_wr", bus.fifo_wr, 0);

    // Prime, then drain two preloaded words on ticks 10 cycles apart
    bus.fifo_threshold = 1'b1;
    bus.fifo_empty     = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      #1;
      check_val($sformatf("drain%0d_rd", k), bus.fifo_rd, 1);
      check_val($sformatf("drain%0d_early_valid", k), bus.out_valid, 0);
      step();
      check_val($sformatf("drain%0d_valid", k), bus.out_valid, 1);
      check_val($sformatf("drain%0d_data", k), bus.out_data, exp_word[k]);
      check_val($sformatf("drain%0d_rd_after", k), bus.fifo_rd, 0);
      if (k == 1) bus.fifo_empty = 1'b1;
      step();
      check_val($sformatf("drain%0d_valid_off", k), bus.out_valid, 0);
      check_val($sformatf("drain%0d_hold", k), bus.out_data, exp_word[k]);
      for (int c = 0; c < 7; c++) step();
      check_val($sformatf("drain%0d_rd_count", k), rd_count, k + 1);
    end

    // Underrun in WAIT
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick    = 1'b0;
    bus.fifo_threshold = 1'b0;
    #1;
    check_val("ur_no_rd", bus.fifo_rd, 0);
    check_val("ur_early_valid", bus.out_valid, 0);
    step();
    check_val("ur_valid", bus.out_valid, 1);
    check_val("ur_data", bus.out_data, exp_ur);
    check_val("ur_cnt", bus.underrun_cnt, 1);
    step();
    check_val("ur_valid_off", bus.out_valid, 0);

    // Re-priming: ticks below threshold are dropped even with data present
    bus.fifo_empty  = 1'b0;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val($sformatf("prime%0d_no_rd", c), bus.fifo_rd, 0);
      step();
    end
    check_val("prime_rd_count", rd_count, 2);
    bus.fifo_threshold = 1'b1;
    step();
    check_val("reprime_no_stale_rd0", bus.fifo_rd, 0);
    step();
    check_val("reprime_no_stale_rd1", bus.fifo_rd, 0);

    // Saturation: underruns 2..300
    bus.fifo_empty = 1'b1;
    for (int n = 2; n <= 300; n++) begin
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      step();
      step();
      if (n == 254) check_val("sat_cnt_254", bus.underrun_cnt, 254);
      if (n == 255) check_val("sat_cnt_255", bus.underrun_cnt, 255);
    end
    check_val("sat_cnt_300", bus.underrun_cnt, 255);
    $display("info saturation run done, underrun_cnt=%0d", bus.underrun_cnt);

    // Reset asserted while in CAP
    bus.fifo_empty  = 1'b0;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    #1;
    check_val("cap_rd", bus.fifo_rd, 1);
    step();
    check_val("cap_valid", bus.out_valid, 1);
    check_val("cap_data", bus.out_data, 8'h33);
    rst_n = 1'b0;
    step();
    check_val("rstcap_out_valid", bus.out_valid, 0);
    check_val("rstcap_out_data", bus.out_data, 8'h80);
    check_val("rstcap_cnt", bus.underrun_cnt, 0);
    check_val("rstcap_rd", bus.fifo_rd, 0);
    rst_n           = 1'b1;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    #1;
    check_val("postrst_no_rd0", bus.fifo_rd, 0);
    step();
    check_val("postrst_no_rd1", bus.fifo_rd, 0);
    check_val("postrst_rd_count", rd_count, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
